mips_mc_controller: RTL

Multicycle control unit that drives the 32-bit datapath ALU (ADD = 3'b010, SUB = 3'b110) and its surrounding registers, muxes and memory enables. It sequences each instruction through fetch, decode and execute states of a Moore FSM. It issues ALUControl from an internal ALU decoder, restricted to the two operations the ALU implements. It sits between the instruction register (Op/Funct fields), the ALU Zero flag, and the datapath select/enable inputs.

---
 rtl/mips_mc_pkg.sv | 41 ++++
 rtl/mips_alu_decoder.sv | 21 ++
 rtl/mips_mc_controller.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Optional JUMP state is enabled with `define MC_JUMP_EN.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEXEC,
    S_ADDIWB
`ifdef MC_JUMP_EN
    , S_JUMP
`endif
  } state_t;

  typedef enum logic [1:0] {
    ADD,
    SUB,
    FUNCT
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

endpackage

// File: rtl/mips_alu_decoder.sv
// ALUOp + Funct to ALUControl; only ADD and SUB are ever produced.
// Combinational, no configuration options.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    unique case (aluop)
      ADD:     alucontrol = ALU_ADD;
      SUB:     alucontrol = ALU_SUB;
      FUNCT:   alucontrol = (funct == F_SUB) ? ALU_SUB : ALU_ADD;
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM (Moore) with output decode.
// Define MC_JUMP_EN to add the j instruction and its JUMP state.
module mips_mc_controller
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal
);

  state_t state, nxt;
  aluop_t aluop;
  logic   pcwrite;
  logic   branch;
  logic   rtype_ok;

  assign rtype_ok = (Op == OP_RTYPE) &&
                    ((Funct == F_ADD) || (Funct == F_SUB));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = S_FETCH;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    Illegal  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = ADD;
    unique case (state)
      S_FETCH: begin
        IRWrite = 1'b1;
        pcwrite = 1'b1;
        ALUSrcB = 2'b01;
        nxt     = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        unique case (1'b1)
          (Op == OP_LW),
          (Op == OP_SW):   nxt = S_MEMADR;
          rtype_ok:        nxt = S_EXECUTE;
          (Op == OP_BEQ):  nxt = S_BRANCH;
          (Op == OP_ADDI): nxt = S_ADDIEXEC;
`ifdef MC_JUMP_EN
          (Op == OP_J):    nxt = S_JUMP;
`endif
          default: begin
            nxt     = S_FETCH;
            Illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD = 1'b1;
        nxt  = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        aluop   = FUNCT;
        nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        aluop   = SUB;
        branch  = 1'b1;
        PCSrc   = 2'b01;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        pcwrite = 1'b1;
        PCSrc   = 2'b10;
      end
`endif
      default: nxt = S_FETCH;
    endcase
  end

  assign PCEn = pcwrite | (branch & Zero);

  mips_alu_decoder u_aludec (
    .aluop      (aluop),
    .funct      (Funct),
    .alucontrol (ALUControl)
  );

endmodule
